// File: rtl/usb_ft245_arbiter.sv
// FT245 parallel-FIFO bus arbiter: queues 32-bit pulse-height words for transmission
// (LSB first) and interleaves single-byte reads, alternating sides under contention.
module usb_ft245_arbiter #(
  parameter int WR_PULSE_TICKS   = 2,
  parameter int RD_PULSE_TICKS   = 2,
  parameter int RX_RECOVER_TICKS = 2,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic [31:0] tx_word,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [7:0]  rx_byte,
  output logic        rx_valid,
  input  logic        rxf,
  input  logic        txe,
  output logic        rd,
  output logic        wr,
  input  logic [7:0]  usb_data_i,
  output logic [7:0]  usb_data_o,
  output logic        usb_data_oe,
  output logic        busy,
  output logic        overflow
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [3:0] RD_LAST  = 4'(RD_PULSE_TICKS - 1);
  localparam logic [3:0] REC_LAST = 4'(RX_RECOVER_TICKS - 1);
  localparam logic [3:0] WR_LAST  = 4'(WR_PULSE_TICKS - 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RX_STROBE  = 3'd1,
    RX_RECOVER = 3'd2,
    TX_SETUP   = 3'd3,
    TX_STROBE  = 3'd4,
    TX_HOLD    = 3'd5
  } state_t;

  state_t          state, state_nxt;
  logic [3:0]      tick_cnt;
  logic            tick_last;
  logic [1:0]      idx;
  logic            last_grant_tx;
  logic [31:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            push, pop, rx_req, tx_req;
  logic [31:0]     head_word;
  logic [7:0]      head_byte;

  // tx_valid/tx_ready: a word is accepted on any rising edge where both are high;
  // tx_valid while tx_ready is low drops the word and raises the sticky overflow flag.
  assign tx_ready = (count != FULL_COUNT);
  assign push     = tx_valid & tx_ready;
  assign pop      = (state == TX_HOLD) && (idx == 2'd3);
  assign rx_req   = ~rxf;
  assign tx_req   = (count != '0) & ~txe;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_word;
  end

  always_ff @(posedge clk) begin
    if (!nRST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (tx_valid && !tx_ready) overflow <= 1'b1;
    end
  end

  always_comb begin
    tick_last = 1'b1;
    case (state)
      RX_STROBE:  tick_last = (tick_cnt == RD_LAST);
      RX_RECOVER: tick_last = (tick_cnt == REC_LAST);
      TX_STROBE:  tick_last = (tick_cnt == WR_LAST);
      default:    tick_last = 1'b1;
    endcase
  end

  // State register plus the counters that move with it.
  always_ff @(posedge clk) begin
    if (!nRST) begin
      state         <= IDLE;
      tick_cnt      <= '0;
      idx           <= '0;
      last_grant_tx <= 1'b1;
      rx_byte       <= '0;
      rx_valid      <= 1'b0;
    end else begin
      state    <= state_nxt;
      tick_cnt <= (state_nxt != state) ? 4'd0 : tick_cnt + 4'd1;
      if (state == TX_HOLD) idx <= idx + 2'd1;
      if (state == IDLE && state_nxt == RX_STROBE) last_grant_tx <= 1'b0;
      if (state == IDLE && state_nxt == TX_SETUP)  last_grant_tx <= 1'b1;
      rx_valid <= 1'b0;
      if (state == RX_STROBE && tick_last) begin
        rx_byte  <= usb_data_i;
        rx_valid <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (rx_req && tx_req) state_nxt = last_grant_tx ? RX_STROBE : TX_SETUP;
        else if (rx_req)      state_nxt = RX_STROBE;
        else if (tx_req)      state_nxt = TX_SETUP;
      end
      RX_STROBE:  if (tick_last) state_nxt = RX_RECOVER;
      RX_RECOVER: if (tick_last) state_nxt = IDLE;
      TX_SETUP:   if (!txe)      state_nxt = TX_STROBE;
      TX_STROBE:  if (tick_last) state_nxt = TX_HOLD;
      // Straight back to TX_SETUP keeps the word atomic against rx requests.
      TX_HOLD:    state_nxt = (idx == 2'd3) ? IDLE : TX_SETUP;
      default:    state_nxt = IDLE;
    endcase
  end

  assign head_word = mem[rd_ptr];

  always_comb begin
    head_byte = head_word[7:0];
    case (idx)
      2'd0: head_byte = head_word[7:0];
      2'd1: head_byte = head_word[15:8];
      2'd2: head_byte = head_word[23:16];
      2'd3: head_byte = head_word[31:24];
      default: head_byte = head_word[7:0];
    endcase
  end

  always_comb begin
    rd          = (state != RX_STROBE);
    wr          = (state != TX_STROBE);
    usb_data_oe = (state == TX_SETUP) || (state == TX_STROBE) || (state == TX_HOLD);
    usb_data_o  = usb_data_oe ? head_byte : 8'h00;
    busy        = (state != IDLE);
  end

endmodule
